// File: rtl/fme_pkg.sv
// Shared constants and helpers for the FME sub-pel interpolators.
// The 6-tap kernel (1,-5,20,20,-5,1) and the rounding/clipping used by all filters.
package fme_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned E_W     = 15;
  localparam int          PIX_MAX = (2 ** PIX_W) - 1;

  localparam int TAP_A = 1;
  localparam int TAP_B = -5;
  localparam int TAP_C = 20;

  localparam int          RND   = 16;
  localparam int unsigned SHIFT = 5;

  function automatic logic [PIX_W-1:0] clip_pix(input int v);
    if (v < 0) begin
      return '0;
    end else if (v > PIX_MAX) begin
      return '1;
    end else begin
      return PIX_W'(v);
    end
  endfunction

endpackage

// File: rtl/fme_round_clip.sv
// Rounds a signed 6-tap filter sum back to pixel range: (e + RND) >>> SHIFT, clipped to 0..255.
module fme_round_clip
  import fme_pkg::*;
(
  input  logic signed [E_W-1:0]   e_i,
  output logic        [PIX_W-1:0] pix_o
);

  int r;

  always_comb begin
    r     = (int'(e_i) + RND) >>> SHIFT;
    pix_o = clip_pix(r);
  end

endmodule

// File: rtl/fme_halfpel_hfilt.sv
// Horizontal half-pel 6-tap interpolator: pixel stream in, half-pel plus left full-pel and column out.
// Two register stages after the window: pair sums, then weighted sum with round/clip.
module fme_halfpel_hfilt
  import fme_pkg::*;
#(
  parameter int unsigned ROW_LEN = 16,
  parameter int unsigned COL_W   = $clog2(ROW_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sol,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_half,
  output logic [PIX_W-1:0] out_full,
  output logic [COL_W-1:0] out_col
);

  localparam int unsigned CNT_W = $clog2(ROW_LEN + 1);
  localparam int unsigned TAPS  = 6;
  localparam int unsigned SUM_W = PIX_W + 1;

  logic [PIX_W-1:0]      win_q [TAPS];
  logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
  logic                  win_ok_q;

  logic                  s1_valid_q;
  logic [SUM_W-1:0]      sa_q, sb_q, sc_q;
  logic [PIX_W-1:0]      s1_full_q;
  logic [COL_W-1:0]      s1_col_q;

  logic signed [E_W-1:0] e;
  logic [PIX_W-1:0]      half;

  logic                  out_valid_q;
  logic [PIX_W-1:0]      out_half_q, out_full_q;
  logic [COL_W-1:0]      out_col_q;

  always_comb begin
    col_cnt_d = col_cnt_q + CNT_W'(1);
    if (in_sol || (col_cnt_q == CNT_W'(ROW_LEN))) begin
      col_cnt_d = CNT_W'(1);
    end
  end

  // win_ok_q pulses once per accepted pixel, so a window held across gaps never re-emits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        win_q[i] <= '0;
      end
      col_cnt_q <= '0;
      win_ok_q  <= 1'b0;
    end else begin
      win_ok_q <= in_valid && (col_cnt_d >= CNT_W'(TAPS));
      if (in_valid) begin
        for (int unsigned i = 0; i < TAPS - 1; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[TAPS-1] <= in_pix;
        col_cnt_q     <= col_cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sa_q       <= '0;
      sb_q       <= '0;
      sc_q       <= '0;
      s1_full_q  <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= win_ok_q;
      if (win_ok_q) begin
        sa_q      <= SUM_W'(win_q[0]) + SUM_W'(win_q[5]);
        sb_q      <= SUM_W'(win_q[1]) + SUM_W'(win_q[4]);
        sc_q      <= SUM_W'(win_q[2]) + SUM_W'(win_q[3]);
        s1_full_q <= win_q[2];
        s1_col_q  <= COL_W'(col_cnt_q - CNT_W'(4));
      end
    end
  end

  always_comb begin
    e = E_W'(TAP_A * int'(sa_q) + TAP_B * int'(sb_q) + TAP_C * int'(sc_q));
  end

  fme_round_clip u_round_clip (
    .e_i   (e),
    .pix_o (half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_half_q  <= '0;
      out_full_q  <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_half_q <= half;
        out_full_q <= s1_full_q;
        out_col_q  <= s1_col_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_half  = out_half_q;
  assign out_full  = out_full_q;
  assign out_col   = out_col_q;

endmodule

// File: doc/fme_halfpel_hfilt.md
Name: fme_halfpel_hfilt

Overview:
Horizontal half-pel interpolator for the FME datapath. It takes a raster stream of 8-bit integer pixels, one per cycle, and applies the H.264 6-tap filter (1,-5,20,20,-5,1). It emits each half-pel sample together with its left-neighbour full pixel and column index. The quarter-pel averaging stage directly downstream consumes these outputs.

Parameters:
- ROW_LEN, 16, integer pixels per row. Must be at least 6. The block emits ROW_LEN-5 half-pels per row.
- COL_W, $clog2(ROW_LEN), width of the column index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_pix is accepted this cycle (no backpressure)
- in_sol  in  1  start of line, qualified by in_valid; this pixel is column 0
- in_pix  in  8  integer pixel, unsigned
- out_valid  out  1  one-cycle pulse per produced half-pel
- out_half  out  8  half-pel sample, rounded and clipped
- out_full  out  8  integer pixel immediately left of the half-pel position
- out_col  out  COL_W  column of out_full within its row

Behaviour:
- Reset: asynchronous, active-high. While rst is high, every register clears: the 6-deep window, col_cnt, pipeline valids, and out_valid/out_half/out_full/out_col = 0. Asserting rst mid-row discards the partial row. After release the block waits for new pixels; in_sol is not required for the first row.
- Window: p0..p5 with p5 newest. On an accepted pixel (edge k) the window shifts and in_pix enters p5. With in_valid low, the window, col_cnt and pipeline inputs hold. Gaps in in_valid are allowed anywhere.
- Column count, updated on accept:
  - in_sol=1 sets col_cnt=1.
  - If col_cnt==ROW_LEN, the pixel implicitly starts a new row: col_cnt=1.
  - Otherwise col_cnt+1.
- win_ok: registered at edge k, equal to 1 when the updated col_cnt >= 6, else 0. Only pixels of the current row contribute; pixels left in the window from the previous row never produce output.
- Stage 1 (edge k+1), when win_ok: sa=p0+p5, sb=p1+p4, sc=p2+p3, each 9-bit unsigned; capture p2 and col=col_cnt-4. Valid propagates to stage 2.
- Stage 2 (edge k+2): E = sa - 5*sb + 20*sc in 15-bit signed; range -2550..10710, no overflow. R = (E+16) >>> 5, arithmetic. out_half = 0 if R<0, 255 if R>255, else R[7:0]. out_full=p2, out_col=col, out_valid=1 for exactly one cycle.
- Latency: 2 cycles from acceptance of the window-completing pixel. Throughput is 1 sample per cycle.
- Simultaneous events:
  - in_sol on the same cycle as the ROW_LEN-th-plus pixel: in_sol wins, col_cnt=1.
  - in_sol while half-pels are in flight: the in-flight results still complete.
- Outputs hold their last values when out_valid=0.

Decomposition:
- Package fme_pkg holds:
  - PIX_W=8.
  - Tap constants TAP_A=1, TAP_B=-5, TAP_C=20.
  - RND=16, SHIFT=5.
  - Function clip_pix(signed) returning 8-bit, shared with other FME interpolators.
- One sub-module, fme_round_clip: combinational 15-bit signed in, 8-bit out; does the +RND, >>>SHIFT and clip. It is reused by the vertical half-pel filter.

Test Plan:
- Flat row, ROW_LEN=16, in_sol then 16 pixels of 100 back-to-back -> 11 out_valid pulses, each out_half=100, out_full=100. out_col runs 2..12; first pulse 2 cycles after the 6th pixel.
- Step window 0,0,0,255,255,255 -> E=4080, out_half=128, out_full=0, out_col=2.
- Clipping:
  - Window 0,0,255,255,0,0 -> E=10200, R=319, out_half=255.
  - Window 255,255,0,0,255,255 -> E=-2040, out_half=0.
  - Window 0,0,255,0,0,0 -> out_half=159.
- Bubbles: same flat row with in_valid low every other cycle -> identical outputs and count. out_valid spaced to match, with no duplicate pulses.
- Row boundary: in_sol asserted after 9 pixels of row A -> only 4 outputs for A. Row B produces no output until its 6th pixel, and row-A pixels never enter a row-B result. Also check implicit wrap after 16 pixels without in_sol.
- Reset mid-row: assert rst while a result is in the pipeline -> all outputs 0 immediately, asynchronously. After release, 5 pixels produce no output and the 6th produces a result.
